// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, arbiter state and op encodings for the register file arbiter
package regfile_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int REG_DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant with a lock override, one-hot output
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  input  arb_state_t state,
  output logic [1:0] grant
);
  // a lock owner is the only grantable port; otherwise the pointer breaks ties
  always_comb
    grant = state == LOCK0 ? {1'b0, valid[0]} :
            state == LOCK1 ? {valid[1], 1'b0} :
            &valid ? (rr_ptr ? 2'b10 : 2'b01) : valid;
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: 32x16 register file shared by two lockable requesters; REGFILE_PORT_ARBITER_STATS_EN adds grant counters
module regfile_port_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_lock,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic                  rsp_we,
  output logic [ADDR_W-1:0]     rsp_addr,
  output logic [DATA_W-1:0]     rsp_rdata,
`ifdef REGFILE_PORT_ARBITER_STATS_EN
  output logic [CNT_W-1:0]      grant_cnt0,
  output logic [CNT_W-1:0]      grant_cnt1,
`endif
  output logic                  locked
);
  import regfile_pkg::*;
  localparam int DEPTH = 2 ** ADDR_W;
  arb_state_t state, state_n, st_eff;
  logic rr_ptr, rr_n, rr_eff, sel, xfer, we, lk;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] regs [DEPTH];
  // grants during reset already reflect the post-reset arbiter
  assign st_eff = reset ? ARB : state;
  assign rr_eff = reset ? 1'b0 : rr_ptr;
  rr_arb2 u_arb (
    .valid  (req_valid),
    .rr_ptr (rr_eff),
    .state  (st_eff),
    .grant  (req_ready)
  );
  assign sel = req_ready[1];
  assign xfer = |req_ready;
  assign we = req_we[sel];
  assign lk = req_lock[sel];
  assign addr = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign locked = state != ARB;
  // lock entry/exit and round-robin pointer movement on each transfer
  always_comb begin
    state_n = state;
    rr_n = rr_ptr;
    if (xfer) begin
      if (state == ARB) begin
        if (&req_valid) rr_n = ~sel;
        if (lk) state_n = sel ? LOCK1 : LOCK0;
      end else if (!lk) begin
        state_n = ARB;
        rr_n = ~sel;
      end
    end
  end
  // arbiter state and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
    end
  end
  // register file storage; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (xfer && we == OP_WRITE) regs[addr] <= wdata;
  end
  // one-cycle response; payload holds between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_we <= 1'b0;
      rsp_addr <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= req_ready;
      if (xfer) begin
        rsp_we <= we;
        rsp_addr <= addr;
        rsp_rdata <= we == OP_WRITE ? wdata : regs[addr];
      end
    end
  end
`ifdef REGFILE_PORT_ARBITER_STATS_EN
  // saturating per-port transfer counters
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req_ready[1] && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed self-checking bench for regfile_port_arbiter
module tb_regfile_port_arbiter;
  logic clk, reset;
  logic [1:0] req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [9:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_we, locked;
  logic [4:0] rsp_addr;
  logic [15:0] rsp_rdata;
  int vectors, errs;
`ifdef REGFILE_PORT_ARBITER_STATS_EN
  logic [1:0] grant_cnt0, grant_cnt1;
`endif
  regfile_port_arbiter #(.CNT_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
`ifdef REGFILE_PORT_ARBITER_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
    req_valid = v;
    req_we = we;
    req_lock = lk;
    req_addr = {a1, a0};
    req_wdata = {d1, d0};
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    clk = 0;
    vectors = 0;
    errs = 0;
    reset = 1;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    tick();
    reset = 0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", req_ready, 0);
    drive(2'b01, 2'b01, 2'b00, 3, 0, 16'hBEEF, 0);
    chk("wr_ready", req_ready, 2'b01);
    tick();
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    chk("wr_rsp_data", rsp_rdata, 16'hBEEF);
    chk("wr_rsp_we", rsp_we, 1);
    chk("wr_rsp_addr", rsp_addr, 3);
    drive(2'b01, 2'b00, 2'b00, 3, 0, 0, 0);
    tick();
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_data", rsp_rdata, 16'hBEEF);
    chk("rd_rsp_we", rsp_we, 0);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_hold_data", rsp_rdata, 16'hBEEF);
    drive(2'b11, 2'b00, 2'b00, 3, 4, 0, 0);
    chk("rr_ready0", req_ready, 2'b01);
    tick();
    chk("rr_rsp0", rsp_valid, 2'b01);
    chk("rr_data0", rsp_rdata, 16'hBEEF);
    chk("rr_ready1", req_ready, 2'b10);
    tick();
    chk("rr_rsp1", rsp_valid, 2'b10);
    chk("rr_addr1", rsp_addr, 4);
    chk("rr_data1", rsp_rdata, 0);
    chk("rr_ready2", req_ready, 2'b01);
    tick();
    chk("rr_rsp2", rsp_valid, 2'b01);
    chk("rr_ready3", req_ready, 2'b10);
    tick();
    chk("rr_rsp3", rsp_valid, 2'b10);
    drive(2'b10, 2'b10, 2'b00, 0, 5, 0, 16'd7);
    tick();
    drive(2'b10, 2'b10, 2'b00, 0, 6, 0, 16'd5);
    tick();
    drive(2'b11, 2'b00, 2'b10, 0, 5, 0, 0);
    chk("lk_pre_ready", req_ready, 2'b01);
    tick();
    chk("lk_first_ready", req_ready, 2'b10);
    tick();
    chk("lk_locked_a", locked, 1);
    chk("lk_data_a", rsp_rdata, 7);
    chk("lk_ready_a", req_ready, 2'b10);
    drive(2'b11, 2'b00, 2'b10, 0, 6, 0, 0);
    tick();
    chk("lk_locked_b", locked, 1);
    chk("lk_data_b", rsp_rdata, 5);
    drive(2'b11, 2'b10, 2'b00, 0, 7, 0, 16'd12);
    chk("lk_ready_c", req_ready, 2'b10);
    tick();
    chk("lk_rsp_c", rsp_valid, 2'b10);
    chk("lk_data_c", rsp_rdata, 12);
    chk("lk_we_c", rsp_we, 1);
    chk("unlk_locked", locked, 0);
    drive(2'b11, 2'b00, 2'b00, 7, 0, 0, 0);
    chk("unlk_ready", req_ready, 2'b01);
    tick();
    chk("unlk_data", rsp_rdata, 12);
    drive(2'b01, 2'b00, 2'b01, 3, 0, 0, 0);
    tick();
    chk("l0_locked", locked, 1);
    drive(2'b11, 2'b01, 2'b01, 3, 3, 16'h1234, 0);
    chk("l0_ready", req_ready, 2'b01);
    reset = 1;
    #1;
    chk("rstcyc_ready", req_ready, 2'b01);
    tick();
    reset = 0;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rdata", rsp_rdata, 0);
    drive(2'b10, 2'b00, 2'b00, 0, 3, 0, 0);
    chk("midrst_p1_ready", req_ready, 2'b10);
    tick();
    chk("midrst_r3", rsp_rdata, 0);
    chk("midrst_rsp", rsp_valid, 2'b10);
    drive(2'b10, 2'b00, 2'b00, 0, 7, 0, 0);
    tick();
    chk("midrst_r7", rsp_rdata, 0);
    drive(2'b01, 2'b01, 2'b00, 31, 0, 16'h0001, 0);
    tick();
    drive(2'b01, 2'b00, 2'b00, 31, 0, 0, 0);
    tick();
    chk("r31_data", rsp_rdata, 16'h0001);
    chk("r31_addr", rsp_addr, 31);
    drive(2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    chk("r0_data", rsp_rdata, 0);
`ifdef REGFILE_PORT_ARBITER_STATS_EN
    chk("cnt0_sat", grant_cnt0, 3);
    chk("cnt1", grant_cnt1, 2);
`endif
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    tick();
    chk("end_idle", rsp_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
